// File: rtl/chacha_host_pkg.sv
// Shared state encoding, field sizes and load-order helper for the ChaCha host driver.
package chacha_host_pkg;

   localparam int KEY_BYTES = 32;
   localparam int NNC_BYTES = 8;
   localparam int CTR_BYTES = 8;
   localparam int BLK_BYTES = 64;

   typedef enum logic [2:0] {
      IDLE,
      LD_KEY,
      LD_NNC,
      LD_CTR,
      WAIT_RDY,
      RD_REQ,
      READ
   } state_t;

   // First load state still selected in sel (key, nonce, counter order), else go wait for the core.
   function automatic state_t first_load(input logic [2:0] sel);
      state_t s;
      if (sel[0])      s = LD_KEY;
      else if (sel[1]) s = LD_NNC;
      else if (sel[2]) s = LD_CTR;
      else             s = WAIT_RDY;
      return s;
   endfunction

endpackage

// File: rtl/chacha_host_timer.sv
// Down-counting timeout for the core block-ready wait; expired fires on the last allowed cycle.
module chacha_host_timer
   import chacha_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= LOAD;
      else if (enable && cnt != '0)
         cnt <= cnt - CW'(1);
   end

   assign expired = enable && (cnt == '0);

endmodule

// File: rtl/chacha_host_driver.sv
// Host-side sequencer for a ChaCha core: loads key/nonce/counter bytes, then streams keystream blocks.
//   state    | meaning
//   IDLE     | ready for a command
//   LD_KEY   | forwarding 32 key bytes to the core
//   LD_NNC   | forwarding 8 nonce bytes
//   LD_CTR   | forwarding 8 counter bytes
//   WAIT_RDY | waiting (timed) for core_blk_ready
//   RD_REQ   | one-cycle block read request
//   READ     | streaming 64 keystream bytes downstream
module chacha_host_driver
   import chacha_host_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_load,
   input  logic [3:0] cmd_blocks,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       err_timeout,
   output logic       core_wr_key,
   output logic       core_wr_nnc,
   output logic       core_wr_ctr,
   output logic       core_rd_blk,
   output logic       core_hold,
   output logic [7:0] core_data_in,
   input  logic       core_blk_ready,
   input  logic [7:0] core_data_out
);

   state_t     state, state_nx;
   logic [2:0] load_q, load_nx;
   logic [4:0] blocks_q, blocks_nx;
   logic [5:0] byte_cnt, byte_nx;
   logic       err_q, err_nx;
   logic       timer_clr, timer_en, timer_exp;
   logic [5:0] field_last;
   logic [2:0] later_sel;

   chacha_host_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clr),
      .enable  (timer_en),
      .expired (timer_exp)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         load_q   <= '0;
         blocks_q <= '0;
         byte_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         load_q   <= load_nx;
         blocks_q <= blocks_nx;
         byte_cnt <= byte_nx;
         err_q    <= err_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      load_nx      = load_q;
      blocks_nx    = blocks_q;
      byte_nx      = byte_cnt;
      err_nx       = err_q;
      cmd_ready    = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_data     = '0;
      out_last     = 1'b0;
      core_wr_key  = 1'b0;
      core_wr_nnc  = 1'b0;
      core_wr_ctr  = 1'b0;
      core_rd_blk  = 1'b0;
      core_hold    = 1'b0;
      core_data_in = '0;
      timer_clr    = 1'b1;
      timer_en     = 1'b0;
      field_last   = 6'(KEY_BYTES - 1);
      later_sel    = load_q & 3'b110;

      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load_nx   = cmd_load;
               blocks_nx = {cmd_blocks == 4'd0, cmd_blocks};
               err_nx    = 1'b0;
               byte_nx   = '0;
               state_nx  = first_load(cmd_load);
            end
         end
         LD_KEY, LD_NNC, LD_CTR: begin
            in_ready     = 1'b1;
            core_data_in = in_data;
            if (state == LD_KEY) begin
               core_wr_key = in_valid;
            end else if (state == LD_NNC) begin
               core_wr_nnc = in_valid;
               field_last  = 6'(NNC_BYTES - 1);
               later_sel   = load_q & 3'b100;
            end else begin
               core_wr_ctr = in_valid;
               field_last  = 6'(CTR_BYTES - 1);
               later_sel   = 3'b000;
            end
            if (in_valid) begin
               if (byte_cnt == field_last) begin
                  byte_nx  = '0;
                  state_nx = first_load(later_sel);
               end else begin
                  byte_nx = byte_cnt + 6'd1;
               end
            end
         end
         WAIT_RDY: begin
            timer_clr = 1'b0;
            timer_en  = 1'b1;
            if (core_blk_ready) begin
               state_nx = RD_REQ;
            end else if (timer_exp) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end
         end
         RD_REQ: begin
            core_rd_blk = 1'b1;
            byte_nx     = '0;
            state_nx    = READ;
         end
         READ: begin
            out_valid = 1'b1;
            out_data  = core_data_out;
            core_hold = ~out_ready;
            out_last  = (byte_cnt == 6'(BLK_BYTES - 1)) && (blocks_q == 5'd1);
            if (out_ready) begin
               if (byte_cnt == 6'(BLK_BYTES - 1)) begin
                  byte_nx   = '0;
                  blocks_nx = blocks_q - 5'd1;
                  state_nx  = (blocks_q == 5'd1) ? IDLE : WAIT_RDY;
               end else begin
                  byte_nx = byte_cnt + 6'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      // Outputs are forced quiet while reset is held, whatever the registered state.
      if (!rst_n) begin
         cmd_ready    = 1'b0;
         in_ready     = 1'b0;
         out_valid    = 1'b0;
         out_data     = '0;
         out_last     = 1'b0;
         core_wr_key  = 1'b0;
         core_wr_nnc  = 1'b0;
         core_wr_ctr  = 1'b0;
         core_rd_blk  = 1'b0;
         core_hold    = 1'b0;
         core_data_in = '0;
      end
   end

   assign err_timeout = err_q && rst_n;

endmodule

// File: tb/tb_chacha_host_driver.sv
// Self-checking bench: command table plus random commands against a byte-stream reference model.
module tb_chacha_host_driver;

   localparam int TMO = 15;
   typedef logic [7:0] u8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_load;
   logic [3:0] cmd_blocks;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       err_timeout;
   logic       core_wr_key, core_wr_nnc, core_wr_ctr;
   logic       core_rd_blk;
   logic       core_hold;
   logic [7:0] core_data_in;
   logic       core_blk_ready;
   logic [7:0] core_data_out;

   always #5 clk = ~clk;

   chacha_host_driver #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_load       (cmd_load),
      .cmd_blocks     (cmd_blocks),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .err_timeout    (err_timeout),
      .core_wr_key    (core_wr_key),
      .core_wr_nnc    (core_wr_nnc),
      .core_wr_ctr    (core_wr_ctr),
      .core_rd_blk    (core_rd_blk),
      .core_hold      (core_hold),
      .core_data_in   (core_data_in),
      .core_blk_ready (core_blk_ready),
      .core_data_out  (core_data_out)
   );

   typedef struct {
      logic [2:0] load;
      logic [3:0] blocks;
      int gap;
      int ordy;
      int e_key, e_nnc, e_ctr, e_rd, e_out;
   } vec_t;

   vec_t vecs[10];
   int n_chk = 0, n_pass = 0;

   // keystream byte k of core block b
   function automatic u8 ks(int b, int k);
      return u8'((b * 64 + k) * 7 + 3);
   endfunction

   // core model: new block on rd_blk, byte pointer advances unless held
   int core_blk = 0, core_k = 0;
   assign core_data_out = ks(core_blk, core_k);
   always @(posedge clk) begin
      if (core_rd_blk) begin
         core_blk <= core_blk + 1;
         core_k   <= 0;
      end else if (!core_hold && core_k < 63) begin
         core_k <= core_k + 1;
      end
   end

   int gap_pct = 0, ordy_pct = 100, rdy_pct = 100, stall_cnt = 0;
   bit blk_ready_en = 1'b1;
   u8  feed_q[$];

   initial begin
      in_valid = 1'b0; in_data = '0;
      forever begin
         @(posedge clk);
         if (in_valid && in_ready && feed_q.size() > 0) void'(feed_q.pop_front());
         #1;
         if (feed_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            in_valid = 1'b1; in_data = feed_q[0];
         end else begin
            in_valid = 1'b0; in_data = u8'($urandom);
         end
      end
   end

   initial begin
      out_ready = 1'b0; core_blk_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
         end else begin
            out_ready = ($urandom_range(99) < ordy_pct);
         end
         core_blk_ready = blk_ready_en && ($urandom_range(99) < rdy_pct);
      end
   end

   // monitor
   int cyc = 0, rd_cnt, out_cnt, data_err, last_err, last_cnt, prot_err, stable_err, hold_cnt;
   int key_first, key_last, blk_base, exp_total;
   u8  key_q[$], nnc_q[$], ctr_q[$];
   logic prev_stall = 1'b0;
   u8    prev_data;

   always @(negedge clk) begin
      cyc++;
      if (core_wr_key) begin
         if (key_q.size() == 0) key_first = cyc;
         key_last = cyc;
         key_q.push_back(core_data_in);
      end
      if (core_wr_nnc) nnc_q.push_back(core_data_in);
      if (core_wr_ctr) ctr_q.push_back(core_data_in);
      if ((core_wr_key || core_wr_nnc || core_wr_ctr) && !(in_valid && in_ready)) prot_err++;
      if (int'(core_wr_key) + int'(core_wr_nnc) + int'(core_wr_ctr) > 1) prot_err++;
      if ((core_wr_key || core_wr_nnc || core_wr_ctr) && core_data_in !== in_data) prot_err++;
      if (core_rd_blk) rd_cnt++;
      if (core_hold !== (out_valid && !out_ready)) prot_err++;
      if (out_valid && in_ready) prot_err++;
      if (out_last && !out_valid) prot_err++;
      if (core_hold) hold_cnt++;
      if (prev_stall && out_valid && out_data !== prev_data) stable_err++;
      if (out_valid && out_ready) begin
         if (out_data !== ks(blk_base + 1 + out_cnt / 64, out_cnt % 64)) data_err++;
         if (out_last !== (out_cnt == exp_total - 1)) last_err++;
         if (out_last) last_cnt++;
         out_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
   end

   task automatic clear_mon();
      rd_cnt = 0; out_cnt = 0; data_err = 0; last_err = 0; last_cnt = 0;
      prot_err = 0; stable_err = 0; hold_cnt = 0; key_first = 0; key_last = 0;
      key_q.delete(); nnc_q.delete(); ctr_q.delete();
   endtask

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int outs_all();
      return int'({cmd_ready, in_ready, out_valid, out_last, err_timeout, core_wr_key, core_wr_nnc,
                   core_wr_ctr, core_rd_blk, core_hold, out_data, core_data_in});
   endfunction

   task automatic send_cmd(logic [2:0] ld, logic [3:0] bl);
      bit acc = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_load = ld; cmd_blocks = bl;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         if (cmd_ready) acc = 1'b1;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("cmd_accept", int'(acc), 1);
   endtask

   task automatic wait_idle(int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      chk("idle_return", int'(cmd_ready), 1);
      #1;
   endtask

   task automatic run_vec(int idx, vec_t v, bit seq);
      u8 sent[$], got[$];
      int nbytes, mism;
      clear_mon();
      gap_pct = v.gap; ordy_pct = v.ordy; blk_ready_en = 1'b1;
      rdy_pct = (idx >= 5) ? 60 : 100;
      exp_total = (v.blocks == 0 ? 16 : int'(v.blocks)) * 64;
      blk_base = core_blk;
      nbytes = (v.load[0] ? 32 : 0) + (v.load[1] ? 8 : 0) + (v.load[2] ? 8 : 0);
      for (int i = 0; i < nbytes; i++) sent.push_back(seq ? u8'(i) : u8'($urandom));
      send_cmd(v.load, v.blocks);
      chk($sformatf("v%0d_err_clear", idx), int'(err_timeout), 0);
      foreach (sent[i]) feed_q.push_back(sent[i]);
      wait_idle(16 * 64 * 4 + 400);
      foreach (key_q[i]) got.push_back(key_q[i]);
      foreach (nnc_q[i]) got.push_back(nnc_q[i]);
      foreach (ctr_q[i]) got.push_back(ctr_q[i]);
      mism = (got.size() > sent.size()) ? got.size() - sent.size() : sent.size() - got.size();
      for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) mism++;
      chk($sformatf("v%0d_key_cnt", idx), key_q.size(), v.e_key);
      chk($sformatf("v%0d_nnc_cnt", idx), nnc_q.size(), v.e_nnc);
      chk($sformatf("v%0d_ctr_cnt", idx), ctr_q.size(), v.e_ctr);
      chk($sformatf("v%0d_load_bytes", idx), mism, 0);
      chk($sformatf("v%0d_rd_blk", idx), rd_cnt, v.e_rd);
      chk($sformatf("v%0d_out_cnt", idx), out_cnt, v.e_out);
      chk($sformatf("v%0d_out_data", idx), data_err, 0);
      chk($sformatf("v%0d_out_last", idx), last_err, 0);
      chk($sformatf("v%0d_last_cnt", idx), last_cnt, 1);
      chk($sformatf("v%0d_protocol", idx), prot_err + stable_err, 0);
      chk($sformatf("v%0d_no_err", idx), int'(err_timeout), 0);
      if (v.gap == 0 && v.load[0]) chk($sformatf("v%0d_key_span", idx), key_last - key_first + 1, 32);
   endtask

   task automatic do_timeout();
      clear_mon();
      blk_ready_en = 1'b0; exp_total = 0;
      send_cmd(3'b000, 4'd1);
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         if (j == 15) begin
            chk("tmo_err_early", int'(err_timeout), 0);
            chk("tmo_busy", int'(cmd_ready), 0);
         end
         if (j == 16) begin
            chk("tmo_err_set", int'(err_timeout), 1);
            chk("tmo_idle", int'(cmd_ready), 1);
         end
      end
      repeat (3) @(negedge clk);
      chk("tmo_sticky", int'(err_timeout), 1);
      chk("tmo_no_rd", rd_cnt, 0);
      #1 blk_ready_en = 1'b1;
   endtask

   task automatic do_stall();
      int i;
      clear_mon();
      gap_pct = 0; ordy_pct = 100; rdy_pct = 100; blk_ready_en = 1'b1;
      exp_total = 64; blk_base = core_blk;
      send_cmd(3'b000, 4'd1);
      for (i = 0; i < 300; i++) begin
         @(posedge clk);
         if (out_cnt >= 20) break;
      end
      stall_cnt = 5;
      #1 cmd_valid = 1'b1; cmd_load = 3'b111; cmd_blocks = 4'd3;
      repeat (3) @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_idle(600);
      chk("stall_hold_cycles", hold_cnt, 5);
      chk("stall_data_stable", stable_err, 0);
      chk("stall_out_cnt", out_cnt, 64);
      chk("stall_out_data", data_err, 0);
      chk("stall_ignored_cmd", key_q.size() + rd_cnt, 1);
      chk("stall_protocol", prot_err + last_err, 0);
   endtask

   task automatic do_reset_abort();
      clear_mon();
      gap_pct = 0; ordy_pct = 100; rdy_pct = 100; blk_ready_en = 1'b1;
      send_cmd(3'b001, 4'd1);
      for (int i = 0; i < 32; i++) feed_q.push_back(u8'($urandom));
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (key_q.size() >= 10) break;
      end
      chk("rst_reached_byte10", int'(key_q.size() >= 10), 1);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_outputs_zero", outs_all(), 0);
      feed_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_err_clear", int'(err_timeout), 0);
   endtask

   initial begin
      vec_t fresh;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = '0; cmd_blocks = '0;
      vecs[0] = '{3'b111, 4'd1, 0, 100, 32, 8, 8, 1, 64};
      vecs[1] = '{3'b000, 4'd2, 0, 100, 0, 0, 0, 2, 128};
      vecs[2] = '{3'b010, 4'd3, 30, 70, 0, 8, 0, 3, 192};
      vecs[3] = '{3'b101, 4'd1, 50, 50, 32, 0, 8, 1, 64};
      vecs[4] = '{3'b000, 4'd0, 0, 80, 0, 0, 0, 16, 1024};
      for (int i = 5; i < 10; i++) begin
         vecs[i].load   = 3'($urandom_range(7));
         vecs[i].blocks = 4'($urandom_range(1, 4));
         vecs[i].gap    = $urandom_range(0, 40);
         vecs[i].ordy   = $urandom_range(50, 100);
         vecs[i].e_key  = vecs[i].load[0] ? 32 : 0;
         vecs[i].e_nnc  = vecs[i].load[1] ? 8 : 0;
         vecs[i].e_ctr  = vecs[i].load[2] ? 8 : 0;
         vecs[i].e_rd   = int'(vecs[i].blocks);
         vecs[i].e_out  = int'(vecs[i].blocks) * 64;
      end
      fresh = '{3'b001, 4'd1, 0, 100, 32, 0, 0, 1, 64};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_zero", outs_all(), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_cmd_ready", int'(cmd_ready), 1);

      run_vec(0, vecs[0], 1'b1);
      run_vec(1, vecs[1], 1'b0);
      do_timeout();
      run_vec(2, vecs[2], 1'b0);
      do_stall();
      do_timeout();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_clears_err", int'(err_timeout), 0);
      for (int i = 3; i < 10; i++) run_vec(i, vecs[i], 1'b0);
      do_reset_abort();
      run_vec(10, fresh, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/chacha_host_driver.md
CHACHA_HOST_DRIVER -- requirements
Module: chacha_host_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023; max cycles spent waiting for core_blk_ready before abort.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock.
  rst_n  input  1  reset, synchronous, active-low.
  cmd_valid  input  1  command offered.
  cmd_ready  output  1  command accepted when high with cmd_valid.
  cmd_load  input  3  bit0 key, bit1 nonce, bit2 counter to load before readout.
  cmd_blocks  input  4  blocks to read; 0 means 16.
  in_valid  input  1  load-byte stream valid.
  in_ready  output  1  load byte consumed when high with in_valid.
  in_data  input  8  load byte.
  out_valid  output  1  keystream byte valid.
  out_ready  input  1  downstream accepts byte.
  out_data  output  8  keystream byte.
  out_last  output  1  final byte of final block.
  err_timeout  output  1  sticky; core never raised blk_ready.
  core_wr_key, core_wr_nnc, core_wr_ctr  output  1 each  core load strobes.
  core_rd_blk  output  1  core block-read request.
  core_hold  output  1  freezes core readout.
  core_data_in  output  8  byte to core.
  core_blk_ready  input  1  core block available.
  core_data_out  input  8  byte from core.

Function
REQ-003 SHALL implement states IDLE, LD_KEY, LD_NNC, LD_CTR, WAIT_RDY, RD_REQ, READ.
REQ-004 SHALL assert cmd_ready only in IDLE; on acceptance, latch cmd_load and cmd_blocks and go to the first selected load state in order key, nonce, counter, else WAIT_RDY.
REQ-005 SHALL load 32 key bytes, 8 nonce bytes, 8 counter bytes, first-received byte first.
REQ-006 SHALL, in each load state, drive in_ready=1, core_data_in=in_data, and the matching core_wr_* = in_valid; a byte transfers only in cycles with in_valid=1.
REQ-007 SHALL advance to the next selected load state (or WAIT_RDY) in the cycle after the last byte of the field transfers; no wr strobe is high outside load states.
REQ-008 SHALL in WAIT_RDY count cycles; on core_blk_ready=1 go to RD_REQ; if the count reaches TIMEOUT_CYCLES first, set err_timeout and return to IDLE.
REQ-009 SHALL in RD_REQ drive core_rd_blk=1 for exactly one cycle, then enter READ with byte index 0.
REQ-010 SHALL in READ drive out_valid=1, out_data=core_data_out, core_hold=~out_ready; byte index increments only on out_valid&out_ready.
REQ-011 SHALL assert out_last with out_valid on byte 63 of the final block only.
REQ-012 SHALL, after byte 63 transfers, decrement the remaining-block count; if nonzero go to WAIT_RDY (timer cleared), else to IDLE.
REQ-013 SHALL drive core_hold=0 outside READ, and out_valid=0, in_ready=0 outside their respective states.
REQ-014 SHALL keep cmd_ready=0 while busy; cmd_valid pulses outside IDLE are ignored, not queued.
REQ-015 SHALL clear err_timeout only on reset or on acceptance of the next command.
REQ-016 SHALL wrap byte index 63->0 and never generate more than cmd_blocks*64 out transfers per command.

Reset
REQ-017 SHALL, with rst_n=0 at a clk edge, enter IDLE and zero all counters, latched command fields and err_timeout, aborting any transfer in progress.
REQ-018 SHALL hold every output at 0 during reset, except cmd_ready, which is 1 on the first cycle after reset release.

Structure
REQ-019 SHALL place the state enum and constants KEY_BYTES=32, NNC_BYTES=8, CTR_BYTES=8, BLK_BYTES=64 in shared package chacha_host_pkg.
REQ-020 SHALL implement the WAIT_RDY timeout as sub-module chacha_host_timer (clear, enable, expired).

Verification
REQ-021 Cmd load=3'b111, blocks=1, 48 bytes 0x00..0x2F with no gaps -> wr_key for 32 cycles, wr_nnc for 8, wr_ctr for 8, core_data_in matches, then one rd_blk pulse.
REQ-022 Cmd load=0, blocks=2, core_blk_ready high -> 128 out transfers, two rd_blk pulses, out_last only on transfer 128.
REQ-023 out_ready low for 5 cycles mid-block -> core_hold high for exactly those 5 cycles, out_data stable, no byte lost or duplicated.
REQ-024 TIMEOUT_CYCLES=15, core_blk_ready held low -> err_timeout=1 after 15 WAIT_RDY cycles, return to IDLE, cmd_ready=1.
REQ-025 rst_n=0 at key byte 10 -> next cycle all outputs 0; after release cmd_ready=1 and a fresh cmd load=1 transfers all 32 key bytes.
REQ-026 cmd_blocks=0 -> exactly 1024 out transfers before IDLE.
